// File: rtl/delay_sum_beamformer_if.sv
// Frame and delay handshake between the TDM receive side and the delay-and-sum beamformer.
// The beamformer takes the slave modport; the sample source/controller takes master.
interface delay_sum_beamformer_if #(
    parameter int MICS         = 2,
    parameter int SAMPLE_WIDTH = 24,
    parameter int DELAY_WIDTH  = 4
);
    logic [MICS-1:0][SAMPLE_WIDTH-1:0] audio_in;
    logic                              audio_valid_in;
    logic [MICS-1:0][DELAY_WIDTH-1:0]  delay_in;
    logic                              delay_load_in;
    logic [SAMPLE_WIDTH-1:0]           audio_out;
    logic                              audio_valid_out;
    logic                              busy_out;

    modport master (
        output audio_in, audio_valid_in, delay_in, delay_load_in,
        input  audio_out, audio_valid_out, busy_out
    );

    modport slave (
        input  audio_in, audio_valid_in, delay_in, delay_load_in,
        output audio_out, audio_valid_out, busy_out
    );
endinterface

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: per-mic sample history, programmable whole-sample delays, averaged output.
// Optional DSB_OVERRUN_EN adds a sticky overrun_out flag for frames dropped while busy.
//
// state | meaning
// IDLE  | waiting for a frame; delay loads apply immediately
// ACC   | summing one delayed mic tap per cycle
// OUT   | averaged sample presented with valid pulse; write pointer advances
module delay_sum_beamformer #(
    parameter int MICS         = 2,
    parameter int SAMPLE_WIDTH = 24,
    parameter int MAX_DELAY    = 16,
    parameter int DELAY_WIDTH  = $clog2(MAX_DELAY)
) (
    input  logic clk_in,
    input  logic rst_in,
`ifdef DSB_OVERRUN_EN
    output logic overrun_out,
`endif
    delay_sum_beamformer_if.slave bus
);
    localparam int MIC_BITS  = $clog2(MICS);
    localparam int ACC_WIDTH = SAMPLE_WIDTH + MIC_BITS;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                           state;
    logic [SAMPLE_WIDTH-1:0]          hist [MICS][MAX_DELAY];
    logic [DELAY_WIDTH-1:0]           wr_ptr;
    logic [MICS-1:0][DELAY_WIDTH-1:0] dly;
    logic [MICS-1:0][DELAY_WIDTH-1:0] dly_pend;
    logic                             pend;
    logic [MIC_BITS-1:0]              mic;
    logic signed [ACC_WIDTH-1:0]      acc;

    logic [DELAY_WIDTH-1:0]           rd_ptr;
    logic [SAMPLE_WIDTH-1:0]          tap_raw;
    logic signed [ACC_WIDTH-1:0]      tap;
    logic signed [ACC_WIDTH-1:0]      acc_next;
    logic signed [SAMPLE_WIDTH-1:0]   avg;

    // Pointer subtraction wraps naturally because MAX_DELAY is a power of two.
    always_comb begin
        rd_ptr   = wr_ptr - dly[mic];
        tap_raw  = hist[mic][rd_ptr];
        tap      = {{MIC_BITS{tap_raw[SAMPLE_WIDTH-1]}}, tap_raw};
        acc_next = acc + tap;
        avg      = SAMPLE_WIDTH'(acc_next >>> MIC_BITS);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state               <= IDLE;
            wr_ptr              <= '0;
            dly                 <= '0;
            dly_pend            <= '0;
            pend                <= 1'b0;
            mic                 <= '0;
            acc                 <= '0;
            bus.audio_out       <= '0;
            bus.audio_valid_out <= 1'b0;
            bus.busy_out        <= 1'b0;
`ifdef DSB_OVERRUN_EN
            overrun_out         <= 1'b0;
`endif
            for (int m = 0; m < MICS; m++) begin
                for (int d = 0; d < MAX_DELAY; d++) begin
                    hist[m][d] <= '0;
                end
            end
        end else begin
            bus.audio_valid_out <= 1'b0;
`ifdef DSB_OVERRUN_EN
            if (bus.audio_valid_in && state != IDLE) begin
                overrun_out <= 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    if (bus.audio_valid_in) begin
                        for (int m = 0; m < MICS; m++) begin
                            hist[m][wr_ptr] <= bus.audio_in[m];
                        end
                        acc          <= '0;
                        mic          <= '0;
                        bus.busy_out <= 1'b1;
                        state        <= ACC;
                        // The frame being accepted must still see the old delays.
                        if (bus.delay_load_in) begin
                            dly_pend <= bus.delay_in;
                            pend     <= 1'b1;
                        end
                    end else if (bus.delay_load_in) begin
                        dly <= bus.delay_in;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    mic <= mic + 1'b1;
                    if (mic == MIC_BITS'(MICS - 1)) begin
                        bus.audio_out       <= avg;
                        bus.audio_valid_out <= 1'b1;
                        state               <= OUT;
                    end
                    if (bus.delay_load_in) begin
                        dly_pend <= bus.delay_in;
                        pend     <= 1'b1;
                    end
                end
                OUT: begin
                    wr_ptr       <= wr_ptr + 1'b1;
                    bus.busy_out <= 1'b0;
                    state        <= IDLE;
                    pend         <= 1'b0;
                    if (bus.delay_load_in) begin
                        dly <= bus.delay_in;
                    end else if (pend) begin
                        dly <= dly_pend;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.busy_out <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Randomized self-checking bench for delay_sum_beamformer against a full-history frame model.
module tb_delay_sum_beamformer;
    localparam int MICS      = 2;
    localparam int SW        = 24;
    localparam int MAX_DELAY = 16;
    localparam int DW        = 4;

    typedef logic [MICS-1:0][SW-1:0] frame_t;
    typedef logic [MICS-1:0][DW-1:0] dly_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    delay_sum_beamformer_if #(.MICS(MICS), .SAMPLE_WIDTH(SW), .DELAY_WIDTH(DW)) bus ();

`ifdef DSB_OVERRUN_EN
    logic overrun;
`endif

    delay_sum_beamformer #(
        .MICS(MICS), .SAMPLE_WIDTH(SW), .MAX_DELAY(MAX_DELAY), .DELAY_WIDTH(DW)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
`ifdef DSB_OVERRUN_EN
        .overrun_out(overrun),
`endif
        .bus(bus)
    );

    // Reference model: every accepted frame since reset, plus the delays in force.
    frame_t fq[$];
    dly_t   mdly;

    function automatic logic [SW-1:0] model_expect();
        longint sum = 0;
        longint q;
        int     k = fq.size() - 1;
        for (int m = 0; m < MICS; m++) begin
            int idx = k - int'(mdly[m]);
            if (idx >= 0) sum += longint'($signed(fq[idx][m]));
        end
        if (sum < 0) q = -((-sum + MICS - 1) / MICS);
        else         q = sum / MICS;
        return q[SW-1:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fq.delete();
        mdly = '0;
    endtask

    task automatic load_delays(input dly_t val);
        @(negedge clk);
        bus.delay_in      = val;
        bus.delay_load_in = 1'b1;
        @(negedge clk);
        bus.delay_load_in = 1'b0;
        mdly = val;
    endtask

    // Drives one frame and observes 12 cycles; load_k = cycle offset of a delay load (-1 none).
    task automatic run_frame(input frame_t smp, input logic dup, input int load_k, input dly_t load_val,
                             output int lat, output logic [SW-1:0] got, output int pulses,
                             output logic busy1);
        @(negedge clk);
        bus.audio_in       = smp;
        bus.audio_valid_in = 1'b1;
        if (load_k == 0) begin
            bus.delay_in      = load_val;
            bus.delay_load_in = 1'b1;
        end
        lat = -1; got = '0; pulses = 0; busy1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.delay_load_in = (load_k == k);
            if (load_k == k) bus.delay_in = load_val;
            bus.audio_valid_in = dup && (k == 1);
            if (dup && k == 1) bus.audio_in = ~smp;
            if (k == 1) busy1 = bus.busy_out;
            if (bus.audio_valid_out) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    got = bus.audio_out;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.audio_out !== '0 || bus.audio_valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got out=%h valid=%b busy=%b exp 0/0/0",
                     bus.audio_out, bus.audio_valid_out, bus.busy_out);
        end
`ifdef DSB_OVERRUN_EN
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_overrun got %b exp 0", overrun);
        end
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fq.delete();
        mdly = '0;
    endtask

    task automatic test_basic();
        frame_t smp; int lat; logic [SW-1:0] got; int pulses; logic busy1;
        smp[0] = 24'h000010;
        smp[1] = 24'h000030;
        run_frame(smp, 1'b0, -1, '0, lat, got, pulses, busy1);
        fq.push_back(smp);
        checks++;
        if (lat !== MICS + 1) begin
            errors++; $display("FAIL basic_latency got %0d exp %0d", lat, MICS + 1);
        end
        checks++;
        if (got !== 24'h000020) begin
            errors++; $display("FAIL basic_value got %h exp 000020", got);
        end
        checks++;
        if (pulses !== 1 || busy1 !== 1'b1 || bus.busy_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_handshake got pulses=%0d busy1=%b busy_end=%b exp 1/1/0",
                     pulses, busy1, bus.busy_out);
        end
    endtask

    task automatic test_delay_ramp();
        frame_t smp; int lat; logic [SW-1:0] got; int pulses; logic busy1;
        dly_t d;
        logic [SW-1:0] exp_v;
        do_reset();
        d[0] = 4'd0; d[1] = 4'd3;
        load_delays(d);
        for (int k = 1; k <= 6; k++) begin
            smp[0] = SW'(k * 16);
            smp[1] = SW'(k * 16);
            run_frame(smp, 1'b0, -1, '0, lat, got, pulses, busy1);
            fq.push_back(smp);
            exp_v = (k <= 3) ? SW'(k * 8) : SW'((k * 16 + (k - 3) * 16) / 2);
            checks++;
            if (got !== exp_v || got !== model_expect() || lat !== MICS + 1) begin
                errors++;
                $display("FAIL ramp_frame%0d got %h lat %0d exp %h lat %0d", k, got, lat, exp_v, MICS + 1);
            end
        end
        checks++;
        if (got !== SW'(72)) begin
            errors++; $display("FAIL ramp_frame6 got %0d exp 72", got);
        end
    endtask

    task automatic test_negative();
        frame_t smp; int lat; logic [SW-1:0] got; int pulses; logic busy1;
        do_reset();
        smp[0] = 24'hFFFFFF;
        smp[1] = 24'hFFFFFE;
        run_frame(smp, 1'b0, -1, '0, lat, got, pulses, busy1);
        fq.push_back(smp);
        checks++;
        if (got !== 24'hFFFFFE) begin
            errors++; $display("FAIL negative_floor got %h exp FFFFFE", got);
        end
    endtask

    task automatic test_wrap();
        frame_t smp; int lat; logic [SW-1:0] got; int pulses; logic busy1;
        dly_t d;
        logic [31:0] r;
        logic [SW-1:0] exp_v;
        do_reset();
        d[0] = 4'd0; d[1] = 4'd15;
        load_delays(d);
        for (int n = 0; n < MAX_DELAY + 2; n++) begin
            for (int m = 0; m < MICS; m++) begin
                r = $urandom();
                smp[m] = r[SW-1:0];
            end
            run_frame(smp, 1'b0, -1, '0, lat, got, pulses, busy1);
            fq.push_back(smp);
            exp_v = model_expect();
            checks++;
            if (got !== exp_v || pulses !== 1) begin
                errors++;
                $display("FAIL wrap_frame%0d got %h pulses %0d exp %h pulses 1", n, got, pulses, exp_v);
            end
        end
    endtask

    task automatic test_random();
        frame_t smp; int lat; logic [SW-1:0] got; int pulses; logic busy1;
        dly_t d;
        logic [31:0] r;
        logic [SW-1:0] exp_v;
        for (int n = 0; n < 30; n++) begin
            if (n % 5 == 0) begin
                for (int m = 0; m < MICS; m++) begin
                    r = $urandom();
                    d[m] = r[DW-1:0];
                end
                load_delays(d);
            end
            for (int m = 0; m < MICS; m++) begin
                r = $urandom();
                smp[m] = r[SW-1:0];
            end
            run_frame(smp, 1'b0, -1, '0, lat, got, pulses, busy1);
            fq.push_back(smp);
            exp_v = model_expect();
            checks++;
            if (got !== exp_v || lat !== MICS + 1) begin
                errors++;
                $display("FAIL random_frame%0d got %h lat %0d exp %h lat %0d", n, got, lat, exp_v, MICS + 1);
            end
        end
    endtask

    task automatic test_overrun();
        frame_t a, b, c; int lat; logic [SW-1:0] got; int pulses; logic busy1;
        dly_t d;
        do_reset();
        d[0] = 4'd0; d[1] = 4'd1;
        load_delays(d);
        a[0] = 24'h000100; a[1] = 24'h000200;
        b[0] = 24'h001000; b[1] = 24'h002000;
        c[0] = 24'h000004; c[1] = 24'h000008;
        run_frame(a, 1'b0, -1, '0, lat, got, pulses, busy1);
        fq.push_back(a);
        run_frame(b, 1'b1, -1, '0, lat, got, pulses, busy1);
        fq.push_back(b);
        checks++;
        if (pulses !== 1 || got !== model_expect()) begin
            errors++;
            $display("FAIL overrun_single_pulse got pulses=%0d out=%h exp 1/%h", pulses, got, model_expect());
        end
        run_frame(c, 1'b0, -1, '0, lat, got, pulses, busy1);
        fq.push_back(c);
        checks++;
        if (got !== model_expect()) begin
            errors++; $display("FAIL overrun_history got %h exp %h", got, model_expect());
        end
`ifdef DSB_OVERRUN_EN
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_flag got %b exp 1", overrun);
        end
`endif
    endtask

    task automatic test_pending_load();
        frame_t smp; int lat; logic [SW-1:0] got; int pulses; logic busy1;
        dly_t d_new;
        logic [31:0] r;
        logic [SW-1:0] exp_v;
        do_reset();
        for (int step = 0; step < 4; step++) begin
            for (int m = 0; m < MICS; m++) begin
                r = $urandom();
                smp[m] = r[SW-1:0];
                d_new[m] = DW'(step + m + 1);
            end
            // Alternate a load during accumulation with a load coincident with the frame.
            run_frame(smp, 1'b0, (step % 2 == 0) ? 1 : 0, d_new, lat, got, pulses, busy1);
            fq.push_back(smp);
            exp_v = model_expect();
            checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL pending_load_step%0d got %h exp %h", step, got, exp_v);
            end
            mdly = d_new;
        end
    endtask

    task automatic test_reset_midframe();
        frame_t smp; int lat; logic [SW-1:0] got; int pulses; logic busy1;
        dly_t d;
        int seen = 0;
        smp[0] = 24'h123456;
        smp[1] = 24'h0ABCDE;
        @(negedge clk);
        bus.audio_in       = smp;
        bus.audio_valid_in = 1'b1;
        @(negedge clk);
        bus.audio_valid_in = 1'b0;
        d[0] = 4'd5; d[1] = 4'd7;
        bus.delay_in       = d;
        bus.delay_load_in  = 1'b1;
        @(negedge clk);
        bus.delay_load_in  = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.audio_out !== '0 || bus.audio_valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset got out=%h valid=%b busy=%b exp 0/0/0",
                     bus.audio_out, bus.audio_valid_out, bus.busy_out);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (bus.audio_valid_out) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL midframe_no_valid got %0d pulses exp 0", seen);
        end
        fq.delete();
        mdly = '0;
        smp[0] = 24'h000400;
        smp[1] = 24'h000600;
        run_frame(smp, 1'b0, -1, '0, lat, got, pulses, busy1);
        fq.push_back(smp);
        checks++;
        if (got !== 24'h000500 || got !== model_expect()) begin
            errors++; $display("FAIL midframe_delays_cleared got %h exp 000500", got);
        end
    endtask

    initial begin
        bus.audio_in       = '0;
        bus.audio_valid_in = 1'b0;
        bus.delay_in       = '0;
        bus.delay_load_in  = 1'b0;
        mdly               = '0;
        test_reset();
        test_basic();
        test_delay_ramp();
        test_negative();
        test_wrap();
        test_random();
        test_pending_load();
        test_overrun();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
